// File: rtl/ad9854_sweep_top.sv
// AD9854 parallel-bus controller: power-up reset, control-register init, FTW1 writes and sweep stepping.
// Optional auto-sweep mode (key0 toggle plus SWEEP_DIV divider) is built only when AUTO_SWEEP_EN is defined.
module ad9854_sweep_top #(
  parameter int SWEEP_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        key0,
  input  logic        add_in,
  input  logic [31:0] Freq_0,
  input  logic [31:0] Freq_1,
  input  logic [31:0] Freq_L_0,
  input  logic [31:0] Freq_L_1,
  input  logic [31:0] dFreq_0,
  input  logic [31:0] dFreq_1,
  output logic        MRST,
  output logic        WR,
  output logic        RD,
  output logic        UDCLK,
  output logic [5:0]  A,
  output logic [7:0]  D,
  output logic        FBH,
  output logic        OSK,
  output logic        mod
);

  typedef enum logic [2:0] {RST_HOLD, RST_WAIT, INIT, FREQ, UPD, IDLE} state_t;

  logic [47:0] start_w, limit_w, inc_w;
  logic [48:0] nxt_w;
  logic        auto_tick;
  logic        unused_bits;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [47:0] cur_q, cur_d;
  logic        pend_q, pend_d;
  logic [2:0]  add_sync_q, add_sync_d;
  logic        add_edge_q, add_edge_d;
  logic        mrst_q, mrst_d, wr_q, wr_d, udclk_q, udclk_d;
  logic [5:0]  a_q, a_d;
  logic [7:0]  d_q, d_d;

  assign start_w = {Freq_1[15:0], Freq_0};
  assign limit_w = {Freq_L_1[15:0], Freq_L_0};
  assign inc_w   = {dFreq_1[15:0], dFreq_0};
  assign nxt_w   = {1'b0, cur_q} + {1'b0, inc_w};

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h10;
      2'd1:    init_byte = 8'h24;
      2'd2:    init_byte = 8'h00;
      default: init_byte = 8'h40;
    endcase
  endfunction

  function automatic logic [7:0] ftw_byte(input logic [47:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    ftw_byte = w[47:40];
      3'd1:    ftw_byte = w[39:32];
      3'd2:    ftw_byte = w[31:24];
      3'd3:    ftw_byte = w[23:16];
      3'd4:    ftw_byte = w[15:8];
      default: ftw_byte = w[7:0];
    endcase
  endfunction

  always_comb begin
    add_sync_d = {add_sync_q[1:0], add_in};
    add_edge_d = add_sync_q[1] & ~add_sync_q[2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    cur_d   = cur_q;
    pend_d  = pend_q;
    case (state_q)
      RST_HOLD: if (cnt_q == 5'd15) begin state_d = RST_WAIT; cnt_d = '0; end
      RST_WAIT: if (cnt_q == 5'd15) begin state_d = INIT; cnt_d = '0; end
      INIT: if (cnt_q == 5'd15) begin
        state_d = FREQ;
        cnt_d   = '0;
        cur_d   = start_w;
      end
      FREQ: if (cnt_q == 5'd23) begin state_d = UPD; cnt_d = '0; end
      UPD:  if (cnt_q == 5'd4)  begin state_d = IDLE; cnt_d = '0; end
      default: begin
        cnt_d = '0;
        if (add_edge_q || auto_tick || pend_q) begin
          state_d = FREQ;
          pend_d  = 1'b0;
          cur_d   = (nxt_w > {1'b0, limit_w}) ? start_w : nxt_w[47:0];
        end
      end
    endcase
    // Requests landing mid-sequence collapse into one deferred step.
    if (state_q != IDLE && (add_edge_q || auto_tick)) pend_d = 1'b1;

    // Pins are decoded from the next state so every output leaves a flop.
    mrst_d  = (state_d == RST_HOLD);
    udclk_d = (state_d == UPD) && (cnt_d < 5'd4);
    wr_d    = 1'b1;
    a_d     = a_q;
    d_d     = d_q;
    case (state_d)
      RST_HOLD, RST_WAIT: begin a_d = '0; d_d = '0; end
      INIT: begin
        a_d  = 6'h1D + {4'b0, cnt_d[3:2]};
        d_d  = init_byte(cnt_d[3:2]);
        wr_d = ~(cnt_d[1] ^ cnt_d[0]);
      end
      FREQ: begin
        a_d  = 6'h04 + {3'b0, cnt_d[4:2]};
        d_d  = ftw_byte(cur_d, cnt_d[4:2]);
        wr_d = ~(cnt_d[1] ^ cnt_d[0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= RST_HOLD;
      cnt_q      <= '0;
      cur_q      <= '0;
      pend_q     <= 1'b0;
      add_sync_q <= '0;
      add_edge_q <= 1'b0;
      mrst_q     <= 1'b1;
      wr_q       <= 1'b1;
      udclk_q    <= 1'b0;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      add_sync_q <= add_sync_d;
      add_edge_q <= add_edge_d;
      mrst_q     <= mrst_d;
      wr_q       <= wr_d;
      udclk_q    <= udclk_d;
      a_q        <= a_d;
      d_q        <= d_d;
    end
  end

  assign MRST  = mrst_q;
  assign WR    = wr_q;
  assign UDCLK = udclk_q;
  assign A     = a_q;
  assign D     = d_q;
  assign RD    = 1'b1;
  assign FBH   = 1'b0;
  assign OSK   = 1'b0;

`ifdef AUTO_SWEEP_EN
  localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_DIV - 1);

  logic [2:0]       key_sync_q, key_sync_d;
  logic             key_edge_q, key_edge_d;
  logic             mod_q, mod_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    key_sync_d = {key_sync_q[1:0], key0};
    key_edge_d = key_sync_q[1] & ~key_sync_q[2];
    mod_d      = mod_q;
    div_d      = div_q;
    auto_tick  = 1'b0;
    if (mod_q) begin
      if (div_q == DIV_LAST) begin
        div_d     = '0;
        auto_tick = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    // Mode flips restart the divider so the first auto step is a full period away.
    if (key_edge_q && state_q != RST_HOLD && state_q != RST_WAIT) begin
      mod_d = ~mod_q;
      div_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      key_sync_q <= '0;
      key_edge_q <= 1'b0;
      mod_q      <= 1'b0;
      div_q      <= '0;
    end else begin
      key_sync_q <= key_sync_d;
      key_edge_q <= key_edge_d;
      mod_q      <= mod_d;
      div_q      <= div_d;
    end
  end

  assign mod         = mod_q;
  assign unused_bits = ^{Freq_1[31:16], Freq_L_1[31:16], dFreq_1[31:16]};
`else
  assign auto_tick   = 1'b0;
  assign mod         = 1'b0;
  assign unused_bits = ^{Freq_1[31:16], Freq_L_1[31:16], dFreq_1[31:16], key0, 1'(SWEEP_DIV)};
`endif

endmodule

// File: tb/tb_ad9854_sweep_top.sv
// Bench for ad9854_sweep_top: bus monitor feeding a byte-write scoreboard, step-vector table, corner sequences.
module tb_ad9854_sweep_top;

  localparam int SDIV = 100;
  localparam logic [47:0] S = 48'h0147AE147AE1;
  localparam logic [47:0] L = 48'h028F5C28F5C2;
  localparam logic [47:0] MAXW = 48'hFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic key0 = 1'b0;
  logic add_in = 1'b0;
  logic [31:0] Freq_0, Freq_1, Freq_L_0, Freq_L_1, dFreq_0, dFreq_1;
  logic MRST, WR, RD, UDCLK, FBH, OSK, mod;
  logic [5:0] A;
  logic [7:0] D;

  ad9854_sweep_top #(.SWEEP_DIV(SDIV)) dut (
    .clk(clk), .rst_in(rst_in), .key0(key0), .add_in(add_in),
    .Freq_0(Freq_0), .Freq_1(Freq_1), .Freq_L_0(Freq_L_0), .Freq_L_1(Freq_L_1),
    .dFreq_0(dFreq_0), .dFreq_1(dFreq_1),
    .MRST(MRST), .WR(WR), .RD(RD), .UDCLK(UDCLK), .A(A), .D(D),
    .FBH(FBH), .OSK(OSK), .mod(mod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] start;
    logic [47:0] limit;
    logic [47:0] inc;
    logic [47:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int udc_rises = 0;
  int udc_hi = 0;
  int rise_cyc[$];
  logic [13:0] sb[$];
  logic wr_prev = 1'b1;
  logic udc_prev = 1'b0;
  logic [47:0] cur_m;
  vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [47:0] step_model(input logic [47:0] c, input logic [47:0] s,
                                             input logic [47:0] l, input logic [47:0] i);
    logic [48:0] n;
    n = {1'b0, c} + {1'b0, i};
    return (n > {1'b0, l}) ? s : n[47:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: a write completes when WR returns high; A/D are still valid in that cycle.
  always @(negedge clk) begin
    if (rst_in) begin
      wr_prev = 1'b1;
      udc_prev = 1'b0;
      udc_hi = 0;
      sb.delete();
    end else begin
      if (!wr_prev && WR) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got A=%0h D=%0h, expected no write", A, D);
        end else begin
          check("byte_write", {A, D}, sb.pop_front());
        end
      end
      wr_prev = WR;
      if (UDCLK) begin
        if (!udc_prev) begin
          udc_rises++;
          rise_cyc.push_back(cyc);
        end
        udc_hi++;
      end else if (udc_prev) begin
        check("udclk_width", udc_hi, 4);
        udc_hi = 0;
      end
      udc_prev = UDCLK;
    end
  end

  task automatic set_freq(input logic [47:0] s, input logic [47:0] l, input logic [47:0] i);
    Freq_0 = s[31:0];   Freq_1 = {16'hABCD, s[47:32]};
    Freq_L_0 = l[31:0]; Freq_L_1 = {16'h5A5A, l[47:32]};
    dFreq_0 = i[31:0];  dFreq_1 = {16'hFFFF, i[47:32]};
  endtask

  task automatic push_ftw(input logic [47:0] w);
    for (int k = 0; k < 6; k++) sb.push_back({6'(4 + k), w[8*(5-k) +: 8]});
  endtask

  task automatic push_init();
    sb.push_back({6'h1D, 8'h10});
    sb.push_back({6'h1E, 8'h24});
    sb.push_back({6'h1F, 8'h00});
    sb.push_back({6'h20, 8'h40});
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int k = 0;
    while (udc_rises < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, 64'(udc_rises >= target), 1);
  endtask

  // Releases reset, loads the expected init traffic and times MRST and the first UDCLK.
  task automatic release_and_time(input string tag);
    int c;
    @(posedge clk); #1;
    rst_in = 1'b0;
    push_init();
    push_ftw(Freq_0 == S[31:0] ? S : {Freq_1[15:0], Freq_0});
    c = 0;
    @(negedge clk);
    while (MRST && c < 100) begin @(negedge clk); c++; end
    check({tag, "_mrst_cycles"}, c, 16);
    while (!UDCLK && c < 200) begin @(negedge clk); c++; end
    check({tag, "_first_udclk"}, c, 72);
  endtask

  task automatic key_pulse();
    @(posedge clk); #1 key0 = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic key_release();
    repeat (55) @(posedge clk);
    #1 key0 = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL global_timeout: got no finish, expected finish within budget");
    $fatal(1);
  end

  initial begin
    int c, r0, r1, n;
    vt[0] = '{S, L, S, L};
    vt[1] = '{S, L, S, S};
    vt[2] = '{48'h000000100000, 48'h000000000010, 48'h1, 48'h000000100000};
    vt[3] = '{48'h0, MAXW, 48'h5, 48'h000000100005};
    vt[4] = '{48'h0, MAXW, MAXW, 48'h0};
    vt[5] = '{48'h123456789ABC, MAXW, 48'h111111111111, 48'h111111111111};
    vt[6] = '{48'h5, 48'h222222222222, 48'h111111111111, 48'h222222222222};
    vt[7] = '{48'h5, 48'h222222222222, 48'h111111111111, 48'h5};

    set_freq(S, L, S);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_MRST", MRST, 1);   check("rst_WR", WR, 1);   check("rst_RD", RD, 1);
    check("rst_UDCLK", UDCLK, 0); check("rst_A", A, 0);     check("rst_D", D, 0);
    check("rst_FBH", FBH, 0);     check("rst_OSK", OSK, 0); check("rst_mod", mod, 0);

    release_and_time("init");
    repeat (10) @(posedge clk);
    check("init_sb_empty", sb.size(), 0);
    check("init_udclk_count", udc_rises, 1);

    // Table of manual steps; each vector chains from the previous current word.
    for (int v = 0; v < 8; v++) begin
      set_freq(vt[v].start, vt[v].limit, vt[v].inc);
      push_ftw(vt[v].exp);
      r0 = udc_rises;
      @(posedge clk); #1 add_in = 1'b1;
      c = 0;
      @(negedge clk);
      while (WR && c < 20) begin @(negedge clk); c++; end
      check($sformatf("step_latency_v%0d", v), c, 5);
      add_in = 1'b0;
      wait_rises(r0 + 1, 60, $sformatf("step_udclk_v%0d", v));
      repeat (10) @(posedge clk);
      check($sformatf("step_sb_empty_v%0d", v), sb.size(), 0);
    end

    // Two requests during INIT collapse into one follow-up step.
    set_freq(S, L, S);
    @(posedge clk); #1 rst_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    push_init(); push_ftw(S); push_ftw(L);
    r0 = udc_rises;
    repeat (33) @(posedge clk);
    #1 add_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 add_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 add_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 add_in = 1'b0;
    wait_rises(r0 + 2, 200, "pend_udclk");
    repeat (80) @(posedge clk);
    check("pend_udclk_count", udc_rises, r0 + 2);
    check("pend_sb_empty", sb.size(), 0);
    cur_m = L;

    set_freq(48'h0, MAXW, 48'h10);
    key_pulse();
`ifdef AUTO_SWEEP_EN
    check("mode_on", mod, 1);
    key_release();
    r0 = udc_rises;
    for (int k = 0; k < 3; k++) begin
      cur_m = step_model(cur_m, 48'h0, MAXW, 48'h10);
      push_ftw(cur_m);
    end
    wait_rises(r0 + 3, 400, "auto_udclk");
    n = rise_cyc.size();
    check("auto_interval_a", rise_cyc[n-1] - rise_cyc[n-2], SDIV);
    check("auto_interval_b", rise_cyc[n-2] - rise_cyc[n-3], SDIV);
    key_pulse();
    check("mode_off", mod, 0);
    key_release();
`else
    check("mode_stays_manual", mod, 0);
    key_release();
`endif
    r1 = udc_rises;
    repeat (300) @(posedge clk);
    check("manual_no_updates", udc_rises, r1);
    check("mode_sb_empty", sb.size(), 0);

    // Reset while the third FTW byte is on the bus.
    set_freq(S, L, S);
    push_ftw(step_model(cur_m, S, L, S));
    @(posedge clk); #1 add_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 add_in = 1'b0;
    c = 0;
    @(negedge clk);
    while (!(A == 6'h06 && !WR) && c < 50) begin @(negedge clk); c++; end
    check("midwrite_reached", 64'(c < 50), 1);
    @(posedge clk); #1 rst_in = 1'b1;
    #1;
    check("midwrite_WR", WR, 1);   check("midwrite_MRST", MRST, 1);
    check("midwrite_A", A, 0);     check("midwrite_D", D, 0);
    repeat (3) @(posedge clk);
    release_and_time("reinit");
    repeat (10) @(posedge clk);
    check("reinit_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
